// File: rtl/comp_data_matcher.sv
// Streaming 64-bit pattern matcher: passes a 32-bit stream through a one-deep register
// stage and flags/counts occurrences of {comp_hi, comp_lo} sent low word first.
module comp_data_matcher #(
    parameter int CNT_W  = 16,
    parameter int BEAT_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] comp_lo,
    input  logic [31:0] comp_hi,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        match_pulse,
    output logic        irq,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        fsm_state
);

    typedef enum logic {
        IDLE    = 1'b0,
        LO_SEEN = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              state_q;
    state_t              state_d;
    logic                hit;
    logic                accept;
    logic                wr;
    logic                enable;
    logic                irq_en;
    logic                sticky;
    logic [CNT_W-1:0]    match_count;
    logic [BEAT_W-1:0]   beat_count;

    // Valid/ready: a beat transfers on a cycle where valid & ready are both high; valid
    // never drops and data never changes while the beat waits for ready.
    assign in_ready  = ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;
    assign wr        = chipselect & ~write_n;
    assign fsm_state = state_q;

    always_comb begin
        state_d = state_q;
        hit     = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else if (accept) begin
            hit     = (state_q == LO_SEEN) && (in_data == comp_hi);
            // A completing or failing beat that equals comp_lo restarts the sequence.
            state_d = (in_data == comp_lo) ? LO_SEEN : IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            out_valid   <= 1'b0;
            out_data    <= '0;
            match_pulse <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_pulse <= hit;
            if (accept) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Control/status registers; a match outranks a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable      <= 1'b0;
            irq_en      <= 1'b0;
            sticky      <= 1'b0;
            irq         <= 1'b0;
            match_count <= '0;
            beat_count  <= '0;
        end else begin
            irq <= irq_en & sticky;

            if (wr && address == 2'd0) begin
                enable <= writedata[0];
                irq_en <= writedata[1];
            end

            if (hit) begin
                sticky <= 1'b1;
            end else if (wr && address == 2'd0 && writedata[2]) begin
                sticky <= 1'b0;
            end

            if (hit) begin
                if (wr && address == 2'd1) begin
                    match_count <= CNT_W'(1);
                end else if (match_count != CNT_MAX) begin
                    match_count <= match_count + CNT_W'(1);
                end
            end else if (wr && address == 2'd1) begin
                match_count <= '0;
            end

            if (accept) begin
                if (wr && address == 2'd2) begin
                    beat_count <= BEAT_W'(1);
                end else begin
                    beat_count <= beat_count + BEAT_W'(1);
                end
            end else if (wr && address == 2'd2) begin
                beat_count <= '0;
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = {29'd0, sticky, irq_en, enable};
            2'd1:    readdata = 32'(match_count);
            2'd2:    readdata = 32'(beat_count);
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_comp_data_matcher.sv
// Bench for comp_data_matcher: stream beats are scoreboarded through an expected queue,
// register behaviour and match/irq races are checked inline per scenario.
module tb_comp_data_matcher;

    localparam int CNT_W  = 4;
    localparam int BEAT_W = 32;
    localparam logic [31:0] LO = 32'h1234_5678;
    localparam logic [31:0] HI = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] comp_lo;
    logic [31:0] comp_hi;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        match_pulse;
    logic        irq;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        fsm_state;

    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          exp_beats = 0;
    logic [31:0] exp_q[$];
    bit          mexp_q[$];
    bit          first_beat = 1'b1;

    comp_data_matcher #(.CNT_W(CNT_W), .BEAT_W(BEAT_W)) dut (
        .clk(clk), .reset_n(reset_n), .comp_lo(comp_lo), .comp_hi(comp_hi),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .match_pulse(match_pulse), .irq(irq), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .fsm_state(fsm_state)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Output monitor / scoreboard
    always @(negedge clk) begin
        bit exp_pulse;
        if (!reset_n) begin
            exp_q.delete();
            mexp_q.delete();
            first_beat = 1'b1;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL sb_underflow: out_valid with data %h, expected no beat", out_data);
            end else begin
                checks++;
                if (out_data !== exp_q[0]) begin
                    fails++;
                    $display("FAIL sb_data: got %h expected %h", out_data, exp_q[0]);
                end
                exp_pulse = first_beat ? mexp_q[0] : 1'b0;
                checks++;
                if (match_pulse !== exp_pulse) begin
                    fails++;
                    $display("FAIL sb_match_pulse: got %b expected %b (data %h)", match_pulse, exp_pulse, exp_q[0]);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(mexp_q.pop_front());
                end
            end
            first_beat = out_ready;
        end else begin
            checks++;
            if (match_pulse !== 1'b0) begin
                fails++;
                $display("FAIL sb_idle_pulse: match_pulse got %b expected 0", match_pulse);
            end
            first_beat = 1'b1;
        end
    end

    // Driver tasks
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input bit m);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; fails++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back(d);
            mexp_q.push_back(m);
            exp_beats++;
            #1;
            in_valid = 1'b0;
        end
    endtask

    // One beat and one register write on the same clock edge; needs out_ready=1.
    task automatic send_wr(input logic [31:0] d, input bit m, input logic [1:0] a, input logic [31:0] wd);
        in_data    = d;
        in_valid   = 1'b1;
        address    = a;
        writedata  = wd;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        exp_q.push_back(d);
        mexp_q.push_back(m);
        exp_beats  = (a == 2'd2) ? 1 : exp_beats + 1;
        #1;
        in_valid   = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] wd);
        address    = a;
        writedata  = wd;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        if (a == 2'd2) exp_beats = 0;
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    // Scenarios
    task automatic test_reset;
        logic [31:0] rd;
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = LO;
        idle(3);
        csr_read(2'd0, rd);
        checks++;
        if (out_valid !== 1'b0 || irq !== 1'b0 || match_pulse !== 1'b0 || fsm_state !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: out_valid=%b irq=%b pulse=%b fsm=%b expected all 0", out_valid, irq, match_pulse, fsm_state);
        end
        checks++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL reset_ctrl: got %h expected 00000000", rd);
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        idle(1);
        checks++;
        if (in_ready !== 1'b1 || out_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b out_data=%h expected 1 / 0", in_ready, out_data);
        end
        for (int a = 1; a < 3; a++) begin
            csr_read(2'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                fails++;
                $display("FAIL reset_reg%0d: got %h expected 00000000", a, rd);
            end
        end
        csr_write(2'd3, 32'hFFFF_FFFF);
        csr_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL reg3_read: got %h expected 00000000", rd);
        end
        csr_read(2'd0, rd);
        checks++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL reg3_write_ignored: ctrl got %h expected 00000000", rd);
        end
    endtask

    task automatic test_basic_match;
        logic [31:0] rd;
        comp_lo = LO;
        comp_hi = HI;
        csr_write(2'd0, 32'h5);
        csr_read(2'd0, rd);
        checks++;
        if (rd !== 32'h1) begin
            fails++;
            $display("FAIL basic_ctrl_enable: got %h expected 00000001", rd);
        end
        csr_write(2'd1, 32'h0);
        csr_write(2'd2, 32'h0);
        send(32'h0, 1'b0);
        send(LO, 1'b0);
        send(HI, 1'b1);
        idle(2);
        csr_read(2'd1, rd);
        checks++;
        if (rd !== 32'd1) begin
            fails++;
            $display("FAIL basic_match_count: got %0d expected 1", rd);
        end
        csr_read(2'd2, rd);
        checks++;
        if (rd !== 32'd3) begin
            fails++;
            $display("FAIL basic_beat_count: got %0d expected 3", rd);
        end
        csr_read(2'd0, rd);
        checks++;
        if (rd !== 32'h5) begin
            fails++;
            $display("FAIL basic_sticky: ctrl got %h expected 00000005", rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        logic [31:0] d;
        int c0;
        csr_write(2'd2, 32'h0);
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            if (d == comp_lo) d = d ^ 32'h1;
            send(d, 1'b0);
        end
        checks++;
        if (cyc - c0 !== 4) begin
            fails++;
            $display("FAIL throughput: 4 beats took %0d cycles expected 4", cyc - c0);
        end
        fork
            for (int i = 0; i < 8; i++) begin
                d = $urandom_range(0, 32'hFFFF);
                send(d, 1'b0);
            end
            begin
                repeat (30) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        idle(3);
        checks++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL b2b_drain: %0d beats outstanding expected 0", exp_q.size());
        end
        csr_read(2'd2, rd);
        checks++;
        if (rd !== 32'd12) begin
            fails++;
            $display("FAIL b2b_beat_count: got %0d expected 12", rd);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd;
        csr_write(2'd0, 32'h5);
        csr_write(2'd1, 32'h0);
        csr_write(2'd2, 32'h0);
        out_ready = 1'b0;
        send(LO, 1'b0);
        idle(2);
        out_ready = 1'b1;
        idle(2);
        out_ready = 1'b0;
        send(HI, 1'b1);
        idle(2);
        checks++;
        if (out_valid !== 1'b1 || out_data !== HI) begin
            fails++;
            $display("FAIL stall_hold: out_valid=%b out_data=%h expected 1 / %h", out_valid, out_data, HI);
        end
        fork
            send(32'h0000_0011, 1'b0);
            begin
                idle(2);
                out_ready = 1'b1;
            end
        join
        idle(3);
        csr_read(2'd1, rd);
        checks++;
        if (rd !== 32'd1) begin
            fails++;
            $display("FAIL bp_match_count: got %0d expected 1", rd);
        end
        csr_read(2'd2, rd);
        checks++;
        if (rd !== 32'd3) begin
            fails++;
            $display("FAIL bp_beat_count: got %0d expected 3", rd);
        end
    endtask

    task automatic test_overlap;
        logic [31:0] rd;
        csr_write(2'd1, 32'h0);
        send(LO, 1'b0);
        send(LO, 1'b0);
        send(HI, 1'b1);
        idle(1);
        csr_read(2'd1, rd);
        checks++;
        if (rd !== 32'd1) begin
            fails++;
            $display("FAIL overlap_lo_lo_hi: got %0d expected 1", rd);
        end
        send(LO, 1'b0);
        send(32'h0, 1'b0);
        send(HI, 1'b0);
        idle(1);
        csr_read(2'd1, rd);
        checks++;
        if (rd !== 32'd1) begin
            fails++;
            $display("FAIL broken_lo_x_hi: got %0d expected 1", rd);
        end
        comp_lo = 32'hAAAA_AAAA;
        comp_hi = 32'hAAAA_AAAA;
        csr_write(2'd1, 32'h0);
        send(32'hAAAA_AAAA, 1'b0);
        send(32'hAAAA_AAAA, 1'b1);
        send(32'hAAAA_AAAA, 1'b1);
        send(32'h0, 1'b0);
        idle(2);
        csr_read(2'd1, rd);
        checks++;
        if (rd !== 32'd2) begin
            fails++;
            $display("FAIL degenerate_pattern: got %0d expected 2", rd);
        end
        comp_lo = LO;
        comp_hi = HI;
    endtask

    task automatic test_irq_races;
        logic [31:0] rd;
        csr_write(2'd0, 32'h7);
        csr_write(2'd1, 32'h0);
        idle(2);
        checks++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL irq_idle: got %b expected 0", irq);
        end
        send(LO, 1'b0);
        send(HI, 1'b1);
        idle(2);
        checks++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL irq_on_match: got %b expected 1", irq);
        end
        send(LO, 1'b0);
        send_wr(HI, 1'b1, 2'd0, 32'h7);
        csr_read(2'd0, rd);
        checks++;
        if (rd !== 32'h7) begin
            fails++;
            $display("FAIL sticky_set_wins: ctrl got %h expected 00000007", rd);
        end
        idle(1);
        checks++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL irq_after_race: got %b expected 1", irq);
        end
        send(LO, 1'b0);
        send_wr(HI, 1'b1, 2'd1, 32'h0);
        csr_read(2'd1, rd);
        checks++;
        if (rd !== 32'd1) begin
            fails++;
            $display("FAIL count_clear_race: got %0d expected 1", rd);
        end
        send_wr(32'h0, 1'b0, 2'd2, 32'h0);
        csr_read(2'd2, rd);
        checks++;
        if (rd !== 32'd1) begin
            fails++;
            $display("FAIL beat_clear_race: got %0d expected 1", rd);
        end
        csr_write(2'd0, 32'h7);
        idle(2);
        csr_read(2'd0, rd);
        checks++;
        if (irq !== 1'b0 || rd !== 32'h3) begin
            fails++;
            $display("FAIL sticky_clear: irq=%b ctrl=%h expected 0 / 00000003", irq, rd);
        end
    endtask

    task automatic test_disable;
        logic [31:0] rd;
        csr_write(2'd0, 32'h1);
        csr_write(2'd1, 32'h0);
        csr_write(2'd2, 32'h0);
        send(LO, 1'b0);
        csr_write(2'd0, 32'h0);
        send(32'h55, 1'b0);
        csr_write(2'd0, 32'h1);
        send(HI, 1'b0);
        idle(2);
        csr_read(2'd1, rd);
        checks++;
        if (rd !== 32'd0) begin
            fails++;
            $display("FAIL disable_breaks_match: got %0d expected 0", rd);
        end
        csr_read(2'd2, rd);
        checks++;
        if (rd !== 32'd3) begin
            fails++;
            $display("FAIL disable_beat_count: got %0d expected 3", rd);
        end
    endtask

    task automatic test_saturation;
        logic [31:0] rd;
        csr_write(2'd1, 32'h0);
        for (int i = 0; i < 20; i++) begin
            send(LO, 1'b0);
            send(HI, 1'b1);
        end
        idle(2);
        csr_read(2'd1, rd);
        checks++;
        if (rd !== 32'd15) begin
            fails++;
            $display("FAIL saturation: got %0d expected 15", rd);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        out_ready = 1'b0;
        send(LO, 1'b0);
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || irq !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: out_valid=%b irq=%b expected 0 / 0", out_valid, irq);
        end
        idle(2);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        exp_beats = 0;
        idle(1);
        csr_write(2'd0, 32'h1);
        send(HI, 1'b0);
        idle(2);
        csr_read(2'd1, rd);
        checks++;
        if (rd !== 32'd0) begin
            fails++;
            $display("FAIL reset_abandons_partial: got %0d expected 0", rd);
        end
        csr_read(2'd2, rd);
        checks++;
        if (rd !== 32'd1) begin
            fails++;
            $display("FAIL reset_beat_count: got %0d expected 1", rd);
        end
    endtask

    initial begin
        comp_lo    = LO;
        comp_hi    = HI;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        reset_n    = 1'b0;

        test_reset();
        test_basic_match();
        test_back_to_back();
        test_backpressure();
        test_overlap();
        test_irq_races();
        test_disable();
        test_saturation();
        test_reset_mid();

        idle(3);
        checks++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL final_drain: %0d beats outstanding expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/comp_data_matcher.md
Name: comp_data_matcher

Overview:
- Consumes the 32-bit compare words driven by the compare-data PIO registers (low word on comp_lo, high word on comp_hi).
- Scans a 32-bit streaming data path for the 64-bit pattern {comp_hi, comp_lo}, sent as two consecutive accepted beats, low word first.
- Passes the stream through a one-deep register stage.
- Flags and counts matches and raises an interrupt. Nios2 controls it through a small Avalon-MM slave.

Parameters:
- CNT_W, 16, width of match counter (saturating)
- BEAT_W, 32, width of accepted-beat counter (wrapping)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- comp_lo  in  32  low compare word (from compare-data PIO out_port)
- comp_hi  in  32  high compare word
- in_data  in  32  stream sink data
- in_valid  in  1  sink valid
- in_ready  out  1  sink ready
- out_data  out  32  stream source data (registered copy of in_data)
- out_valid  out  1  source valid
- out_ready  in  1  source ready
- match_pulse  out  1  one-cycle pulse aligned with out_valid of the completing high beat
- irq  out  1  interrupt, level
- address  in  2  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, zero wait states, combinational mux

Behaviour:
- Reset (async, reset_n=0): out_valid=0, out_data=0, match_pulse=0, irq=0, FSM=IDLE, enable=0, irq_en=0, sticky=0, match_count=0, beat_count=0.
- Reset asserted mid-operation: any held beat is discarded and any partial match is abandoned.
- Handshake:
  - in_ready = ~out_valid | out_ready.
  - accept = in_valid & in_ready.
  - On accept: out_data<=in_data and out_valid<=1.
  - Otherwise, if out_ready: out_valid<=0.
  - Full throughput: 1 beat/cycle when out_ready is held high.
  - Latency in->out: 1 cycle. out_data is stable while out_valid & ~out_ready.
- beat_count increments on every accept regardless of enable and wraps at 2^BEAT_W.
- comp_lo and comp_hi are sampled live on the accepting cycle; no shadowing.
- FSM (advances only on accept, and only while enable=1):
  - IDLE: in_data==comp_lo -> LO_SEEN; else stay IDLE.
  - LO_SEEN, in_data==comp_hi: match; next state = LO_SEEN if in_data==comp_lo, else IDLE.
  - LO_SEEN, in_data!=comp_hi: next state = LO_SEEN if in_data==comp_lo (overlap restart), else IDLE.
  - Non-accepting cycles hold the state; bubbles do not break a sequence.
  - enable=0 forces IDLE synchronously. A partial match does not survive a disable.
- Match is registered on the accepting cycle:
  - match_pulse=1 for exactly one cycle, the first cycle out_valid shows the high beat.
  - match_count += 1, saturating at 2^CNT_W-1.
  - sticky<=1.
- Degenerate pattern comp_lo==comp_hi=X: stream X,X,X gives 2 matches (beats 2 and 3).
- irq = irq_en & sticky, registered.
- Register map (write = chipselect & ~write_n):
  - 0 CTRL/STATUS: bit0 enable RW; bit1 irq_en RW; bit2 sticky, read value, write 1 clears; bits 31:3 read 0.
  - 1 MATCH_COUNT: RO, zero-extended; any write clears.
  - 2 BEAT_COUNT: RO; any write clears.
  - 3: reads 0, writes ignored.
- Simultaneous-event priorities:
  - sticky write-1-clear and a match in the same cycle: sticky=1 (set wins).
  - MATCH_COUNT clear and a match in the same cycle: count=1.
  - BEAT_COUNT clear and an accept in the same cycle: count=1.
- readdata = selected register regardless of chipselect.

Test Plan:
- Reset/idle: hold reset_n=0 with in_valid=1 -> out_valid=0, irq=0, readdata@0=0. Release -> in_ready=1.
- Basic match: comp_lo=0x1234_5678, comp_hi=0xDEAD_BEEF, enable=1, stream 0x0, 0x12345678, 0xDEADBEEF, out_ready=1 -> match_pulse on the cycle out_data=0xDEADBEEF, MATCH_COUNT=1, BEAT_COUNT=3, sticky=1.
- Backpressure/bubbles: same pattern with in_valid gap of 3 cycles between lo and hi and out_ready low for 2 cycles -> no beat lost or duplicated, match still detected, out_data held while stalled.
- Overlap/mismatch:
  - lo, lo, hi -> 1 match.
  - lo, 0x0, hi -> 0 matches.
  - comp_lo=comp_hi=0xAAAA_AAAA with 3 beats of 0xAAAAAAAA -> MATCH_COUNT=2.
- IRQ/clear races: irq_en=1, match -> irq=1. Write CTRL=0x7 in the same cycle as a new match -> sticky stays 1, irq stays 1. Write MATCH_COUNT on a match cycle -> reads 1.
- Disable mid-sequence and saturation:
  - Accept lo, set enable=0, re-enable, accept hi -> no match.
  - With CNT_W=4, generate 20 matches -> MATCH_COUNT=15.
